spi_reg_slave: RTL and testbench

- Front-end stage of tt_um_control_block: an SPI (mode 0) write-only peripheral that deserialises 16-bit frames from the ui_in pins and updates a small bank of 8-bit configuration registers.
- The downstream control/PWM logic reads these registers.
- Runs entirely in the system clock domain. SCLK, COPI and nCS are oversampled through synchronisers, so SCLK is never used as a clock.

---
 rtl/control_pkg.sv | 20 ++
 rtl/sync_edge.sv | 32 +++
 rtl/spi_reg_slave.sv | 124 ++++++++++++
 tb/tb_spi_reg_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the tt_um_control_block front end and its consumers.
package control_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned OVERRUN    = FRAME_BITS + 1;

  localparam int unsigned REG_EN_OUT  = 0;
  localparam int unsigned REG_EN_UIO  = 1;
  localparam int unsigned REG_PWM_OUT = 2;
  localparam int unsigned REG_PWM_UIO = 3;
  localparam int unsigned REG_DUTY    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with a history flop so
// rise/fall events can be decoded as single-cycle pulses.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= STAGES'({r_sync, i_async});
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level  = r_sync[STAGES-1];
  assign o_rise_c =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only slave: oversamples SCLK/COPI/nCS in the system clock
// domain, deserialises 16-bit frames and commits them to an 8-bit register bank.
module spi_reg_slave
  import control_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_sclk,
  input  logic                       spi_copi,
  input  logic                       spi_ncs,
  output logic [8*NUM_REGS-1:0]      regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       frame_err
);

  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic w_sclk_rise, w_sclk_fall_unused, w_sclk_level_unused;
  logic w_copi, w_copi_rise_unused, w_copi_fall_unused;
  logic w_ncs_level, w_ncs_rise, w_ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_async  (spi_sclk),
    .o_level  (w_sclk_level_unused),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_async  (spi_copi),
    .o_level  (w_copi),
    .o_rise_c (w_copi_rise_unused),
    .o_fall_c (w_copi_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_async  (spi_ncs),
    .o_level  (w_ncs_level),
    .o_rise_c (w_ncs_rise),
    .o_fall_c (w_ncs_fall)
  );

  state_e                             r_state;
  logic [CNT_W-1:0]                   r_bit_cnt;
  logic [FRAME_BITS-1:0]              r_shift;
  logic [NUM_REGS-1:0][DATA_W-1:0]    r_bank;
  logic [SETTLE_W-1:0]                r_settle;
  logic                               r_armed;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_frame_ok;

  assign w_addr     = r_shift[FRAME_BITS-2 -: ADDR_W];
  assign w_data     = r_shift[DATA_W-1:0];
  assign w_frame_ok = (r_bit_cnt == CNT_W'(FRAME_BITS)) && r_shift[FRAME_BITS-1]
                      && (32'(w_addr) < NUM_REGS);
  assign regs       = r_bank;

  // Only a fall seen after nCS has genuinely been high opens a frame; this
  // keeps a reset released with nCS held low from starting mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_bank    <= '0;
      r_settle  <= '0;
      r_armed   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (r_settle != SETTLE_W'(SYNC_STAGES)) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end else if (w_ncs_level) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_ncs_fall && r_armed) begin
            r_state   <= RECV;
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
        end
        RECV: begin
          if (w_ncs_rise) begin
            r_state <= IDLE;
            if (w_frame_ok) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_addr == ADDR_W'(i)) r_bank[i] <= w_data;
              end
              wr_strobe <= 1'b1;
              wr_addr   <= w_addr;
              wr_data   <= w_data;
            end else if (r_bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
            if (r_bit_cnt != CNT_W'(OVERRUN)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: vector table, hand-written corner
// sequences and random frames against a frame-level reference model.
module tb_spi_reg_slave;

  localparam int NR = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sclk, copi, ncs;
  logic [8*NR-1:0] regs;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  m_regs [NR];
  bit          m_err;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  typedef struct {
    logic [31:0] val;
    int          nbits;
    bit          pre_reset;
    int          exp_strobe;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[11];

  spi_reg_slave #(.NUM_REGS(NR), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (sclk),
    .spi_copi  (copi),
    .spi_ncs   (ncs),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture commits; the register must already hold the strobed data.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      if (int'(wr_addr) < NR) check("strobe_reg_same_cycle", 32'(regs[int'(wr_addr)*8 +: 8]), 32'(wr_data));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what a frame of n bits ending in val must do.
  task automatic model(input logic [31:0] val, input int n);
    logic [15:0] f;
    int          a;
    f = val[15:0];
    a = int'(f[14:8]);
    if (n == 16 && f[15] && a < NR) begin
      m_regs[a] = f[7:0];
      exp_q.push_back(f[14:0]);
    end else if (n != 0) begin
      m_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    sclk = 1'b0; copi = 1'b0;
    rst_n = 1'b0;
    tick(3);
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_err = 1'b0;
    exp_q.delete();
    obs_q.delete();
    check("reset_regs", 32'(regs), 32'd0);
    check("reset_strobe", 32'(wr_strobe), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] val, input int n);
    sclk = 1'b0;
    ncs  = 1'b0;
    tick(4);
    shift_bits(val, n);
    tick(4);
    ncs = 1'b1;
  endtask

  task automatic check_after(input string tag);
    tick(8);
    check({tag, "_strobes"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_addr_data"}, 32'(obs_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < NR; i++)
      check({tag, "_reg"}, 32'(regs[i*8 +: 8]), 32'(m_regs[i]));
    check({tag, "_err"}, 32'(frame_err), 32'(m_err));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic prefill();
    send(32'h825A, 16);
    model(32'h825A, 16);
    check_after("prefill");
  endtask

  initial begin
    logic [31:0] v;
    int          n;

    vecs[0]  = '{32'h80F0,  16, 1'b1, 1, 7'h00, 8'hF0, 1'b0};
    vecs[1]  = '{32'h8455,  16, 1'b0, 1, 7'h04, 8'h55, 1'b0};
    vecs[2]  = '{32'h81AA,  16, 1'b0, 1, 7'h01, 8'hAA, 1'b0};
    vecs[3]  = '{32'h8233,  16, 1'b0, 1, 7'h02, 8'h33, 1'b0};
    vecs[4]  = '{32'h83C3,  16, 1'b0, 1, 7'h03, 8'hC3, 1'b0};
    vecs[5]  = '{32'h0000,   0, 1'b0, 0, 7'h00, 8'h00, 1'b0};
    vecs[6]  = '{32'h0033,  16, 1'b1, 0, 7'h00, 8'h00, 1'b1};
    vecs[7]  = '{32'h8533,  16, 1'b1, 0, 7'h00, 8'h00, 1'b1};
    vecs[8]  = '{32'h4078,  15, 1'b1, 0, 7'h00, 8'h00, 1'b1};
    vecs[9]  = '{32'h180F0, 17, 1'b1, 0, 7'h00, 8'h00, 1'b1};
    vecs[10] = '{32'h80F0F, 20, 1'b1, 0, 7'h00, 8'h00, 1'b1};

    ncs = 1'b1;
    do_reset();

    foreach (vecs[k]) begin
      if (vecs[k].pre_reset) begin
        do_reset();
        prefill();
      end
      send(vecs[k].val, vecs[k].nbits);
      model(vecs[k].val, vecs[k].nbits);
      tick(8);
      check("vec_strobe_count", 32'(obs_q.size()), 32'(vecs[k].exp_strobe));
      if (vecs[k].exp_strobe == 1 && obs_q.size() == 1)
        check("vec_addr_data", 32'(obs_q[0]), 32'({vecs[k].exp_addr, vecs[k].exp_data}));
      check("vec_err", 32'(frame_err), 32'(vecs[k].exp_err));
      check_after("vec");
    end

    // Back-to-back frames separated by a single clock of nCS high.
    do_reset();
    send(32'h8455, 16);
    tick(1);
    send(32'h81AA, 16);
    model(32'h8455, 16);
    model(32'h81AA, 16);
    check_after("b2b");

    // 17th SCLK rise coincides with nCS rise: the nCS rise wins.
    ncs = 1'b0;
    tick(4);
    shift_bits(32'h8399, 16);
    copi = 1'b1;
    tick(4);
    sclk = 1'b1;
    ncs  = 1'b1;
    tick(4);
    sclk = 1'b0;
    model(32'h8399, 16);
    check_after("race");

    // Reset in the middle of a frame, nCS held low through release.
    prefill();
    ncs = 1'b0;
    tick(4);
    shift_bits(32'h81, 8);
    rst_n = 1'b0;
    tick(2);
    check("midrst_regs", 32'(regs), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_err = 1'b0;
    obs_q.delete();
    exp_q.delete();
    shift_bits(32'h81, 8);
    tick(4);
    ncs = 1'b1;
    check_after("midrst_stale");
    tick(4);
    send(32'h8177, 16);
    model(32'h8177, 16);
    check_after("midrst_next");

    // SCLK/COPI noise with nCS idle.
    prefill();
    for (int c = 0; c < 25; c++) begin
      sclk = ~sclk;
      copi = 1'($urandom);
      tick(4);
    end
    sclk = 1'b0;
    check_after("idle_noise");

    // Random frames against the reference model.
    for (int r = 0; r < 30; r++) begin
      if (r % 10 == 0) do_reset();
      case ($urandom_range(0, 9))
        7:       n = 15;
        8:       n = 17;
        9:       n = 0;
        default: n = 16;
      endcase
      v = $urandom;
      v[15]   = ($urandom_range(0, 3) != 0);
      v[14:8] = 7'($urandom_range(0, 6));
      send(v, n);
      model(v, n);
      check_after("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
